// File: rtl/mem_pkg.sv
// mem_pkg: op/state encodings and access-size helpers for the data-memory unit
package mem_pkg;
    typedef enum logic [2:0] {OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB} op_t;
    typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
    function automatic logic is_store(input op_t op);
        return op >= OP_SW;
    endfunction
    // 0 = byte, 1 = half, 2 = word
    function automatic logic [1:0] size(input op_t op);
        return (op == OP_LW || op == OP_SW) ? 2'd2 :
               (op == OP_LH || op == OP_LHU || op == OP_SH) ? 2'd1 : 2'd0;
    endfunction
    function automatic logic misaligned(input op_t op, input logic [1:0] a);
        return size(op) == 2'd2 ? a != 2'b00 : size(op) == 2'd1 ? a[0] : 1'b0;
    endfunction
endpackage

// File: rtl/load_align.sv
// load_align: pick the addressed byte/half out of a read word and extend it to 32 bits
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  op_t         op,
    output logic [31:0] result
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[8*addr +: 8];
    assign h = addr[1] ? rdata[31:16] : rdata[15:0];
    always_comb begin
        result = op == OP_LB  ? {{24{b[7]}}, b} :
                 op == OP_LBU ? {24'b0, b} :
                 op == OP_LH  ? {{16{h[15]}}, h} :
                 op == OP_LHU ? {16'b0, h} : rdata;
    end
endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store sequencer with lane steering, timeout and load extension
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int CW = $clog2(TIMEOUT + 1);
    state_t         state;
    op_t            op_q;
    logic [1:0]     a_q;
    logic [CW-1:0]  cnt;
    op_t            op_in;
    logic [1:0]     a_in;
    logic [3:0]     be_n;
    logic [31:0]    wd_n;
    logic [31:0]    ld;
    assign op_in     = op_t'(req_op);
    assign a_in      = req_addr[1:0];
    assign req_ready = state == IDLE;
    always_comb begin
        be_n = size(op_in) == 2'd0 ? 4'b0001 << a_in :
               size(op_in) == 2'd1 ? (a_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
        wd_n = !is_store(op_in)    ? 32'b0 :
               size(op_in) == 2'd0 ? {4{req_wdata[7:0]}} :
               size(op_in) == 2'd1 ? {2{req_wdata[15:0]}} : req_wdata;
    end
    load_align u_align (.rdata(mem_rdata), .addr(a_q), .op(op_q), .result(ld));
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op_q       <= OP_LW;
            a_q        <= 2'b00;
            cnt        <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    op_q <= op_in;
                    a_q  <= a_in;
                    cnt  <= '0;
                    if (misaligned(op_in, a_in)) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b1;
                        resp_rdata <= '0;
                    end else begin
                        state     <= ISSUE;
                        mem_req   <= 1'b1;
                        mem_we    <= is_store(op_in);
                        mem_addr  <= {req_addr[31:2], 2'b00};
                        mem_be    <= be_n;
                        mem_wdata <= wd_n;
                    end
                end
                ISSUE: if (mem_ack || cnt == CW'(TIMEOUT - 1)) begin
                    // an ack in the final allowed cycle beats the timeout
                    state      <= RESP;
                    mem_req    <= 1'b0;
                    mem_we     <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_err   <= !mem_ack;
                    resp_rdata <= (!mem_ack || is_store(op_q)) ? 32'b0 : ld;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store, misalignment, timeout and reset checks
module tb_mem_access_unit;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3, LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    int errors = 0;
    int checks = 0;
    always #5 clk = ~clk;
    mem_access_unit #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err)
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd);
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        step();
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h5555_5555;
    endtask
    task automatic access(input string tag, input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int waits, input logic [31:0] rd, input logic [31:0] ea, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic ewe, input logic [31:0] erd);
        check({tag, " ready"}, {31'b0, req_ready}, 32'd1);
        send(op, addr, wd);
        check({tag, " req"}, {31'b0, mem_req}, 32'd1);
        check({tag, " we"}, {31'b0, mem_we}, {31'b0, ewe});
        check({tag, " addr"}, mem_addr, ea);
        check({tag, " be"}, {28'b0, mem_be}, {28'b0, ebe});
        check({tag, " wdata"}, mem_wdata, ewd);
        for (int i = 0; i < waits; i++) begin
            check({tag, " wait resp"}, {31'b0, resp_valid}, 32'd0);
            step();
            check({tag, " wait addr"}, mem_addr, ea);
        end
        check({tag, " req at ack"}, {31'b0, mem_req}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = rd;
        step();
        mem_ack   = 1'b0;
        mem_rdata = 32'hA5A5_5A5A;
        check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, " resp_rdata"}, resp_rdata, erd);
        check({tag, " resp_err"}, {31'b0, resp_err}, 32'd0);
        check({tag, " req dropped"}, {31'b0, mem_req}, 32'd0);
        step();
        check({tag, " pulse end"}, {31'b0, resp_valid}, 32'd0);
    endtask
    task automatic misalign(input string tag, input logic [2:0] op, input logic [31:0] addr);
        send(op, addr, 32'h1234_5678);
        check({tag, " resp_valid"}, {31'b0, resp_valid}, 32'd1);
        check({tag, " resp_err"}, {31'b0, resp_err}, 32'd1);
        check({tag, " resp_rdata"}, resp_rdata, 32'd0);
        check({tag, " no req"}, {31'b0, mem_req}, 32'd0);
        step();
        check({tag, " pulse end"}, {31'b0, resp_valid}, 32'd0);
        check({tag, " no req after"}, {31'b0, mem_req}, 32'd0);
    endtask
    initial begin
        step();
        step();
        check("rst ready", {31'b0, req_ready}, 32'd1);
        check("rst mem_req", {31'b0, mem_req}, 32'd0);
        check("rst mem_we", {31'b0, mem_we}, 32'd0);
        check("rst resp_valid", {31'b0, resp_valid}, 32'd0);
        check("rst resp_err", {31'b0, resp_err}, 32'd0);
        check("rst mem_addr", mem_addr, 32'd0);
        check("rst mem_be", {28'b0, mem_be}, 32'd0);
        check("rst mem_wdata", mem_wdata, 32'd0);
        check("rst resp_rdata", resp_rdata, 32'd0);
        reset = 1'b0;
        step();
        access("sb", SB, 32'h0000_1003, 32'h0000_00A5, 0, 32'hFFFF_FFFF, 32'h0000_1000, 4'b1000, 32'hA5A5_A5A5, 1'b1, 32'h0);
        access("sh", SH, 32'h0000_1002, 32'h1234_BEEF, 1, 32'hFFFF_FFFF, 32'h0000_1000, 4'b1100, 32'hBEEF_BEEF, 1'b1, 32'h0);
        access("sw", SW, 32'h0000_1004, 32'h1234_BEEF, 0, 32'hFFFF_FFFF, 32'h0000_1004, 4'b1111, 32'h1234_BEEF, 1'b1, 32'h0);
        access("lb", LB, 32'h0000_2002, 32'h0, 3, 32'h12F0_3456, 32'h0000_2000, 4'b0100, 32'h0, 1'b0, 32'hFFFF_FFF0);
        access("lbu", LBU, 32'h0000_2002, 32'h0, 3, 32'h12F0_3456, 32'h0000_2000, 4'b0100, 32'h0, 1'b0, 32'h0000_00F0);
        access("lb1", LB, 32'h0000_2001, 32'h0, 0, 32'h12F0_3456, 32'h0000_2000, 4'b0010, 32'h0, 1'b0, 32'h0000_0034);
        access("lh", LH, 32'h0000_3002, 32'h0, 0, 32'h8001_7FFF, 32'h0000_3000, 4'b1100, 32'h0, 1'b0, 32'hFFFF_8001);
        access("lhu", LHU, 32'h0000_3002, 32'h0, 0, 32'h8001_7FFF, 32'h0000_3000, 4'b1100, 32'h0, 1'b0, 32'h0000_8001);
        access("lh0", LH, 32'h0000_3000, 32'h0, 0, 32'h8001_7FFF, 32'h0000_3000, 4'b0011, 32'h0, 1'b0, 32'h0000_7FFF);
        access("lw", LW, 32'h0000_3000, 32'h0, 0, 32'h8001_7FFF, 32'h0000_3000, 4'b1111, 32'h0, 1'b0, 32'h8001_7FFF);
        misalign("mis lw", LW, 32'h0000_4001);
        misalign("mis sh", SH, 32'h0000_4003);
        send(LW, 32'h0000_5000, 32'h0);
        for (int i = 0; i < 16; i++) begin
            check("to req high", {31'b0, mem_req}, 32'd1);
            check("to no resp", {31'b0, resp_valid}, 32'd0);
            step();
        end
        check("to req low", {31'b0, mem_req}, 32'd0);
        check("to resp_valid", {31'b0, resp_valid}, 32'd1);
        check("to resp_err", {31'b0, resp_err}, 32'd1);
        check("to resp_rdata", resp_rdata, 32'd0);
        step();
        access("ack16", LW, 32'h0000_5000, 32'h0, 15, 32'hDEAD_BEEF, 32'h0000_5000, 4'b1111, 32'h0, 1'b0, 32'hDEAD_BEEF);
        send(LW, 32'h0000_6000, 32'h0);
        step();
        step();
        check("rst mid req", {31'b0, mem_req}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst mid req low", {31'b0, mem_req}, 32'd0);
        check("rst mid no resp", {31'b0, resp_valid}, 32'd0);
        check("rst mid ready", {31'b0, req_ready}, 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h1111_1111;
        step();
        mem_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray ack no resp", {31'b0, resp_valid}, 32'd0);
            check("stray ack no req", {31'b0, mem_req}, 32'd0);
            step();
        end
        access("after rst", LBU, 32'h0000_7003, 32'h0, 2, 32'h9A00_0000, 32'h0000_7000, 4'b1000, 32'h0, 1'b0, 32'h0000_009A);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
